// File: rtl/elastic_pipe.sv
// Elastic register pipeline with per-stage flush and stall.
// A move/load chain resolved from the output end backwards lets a full
// pipe advance every stage in one cycle. Per-stage taps allow forwarding.
// Accepted items are counted with wrap-around; flushed items are counted
// with saturation.
module elastic_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic [DEPTH-1:0]           flush_i,
  input  logic [DEPTH-1:0]           stall_i,
  output logic [DEPTH-1:0]           stage_valid_o,
  output logic [DEPTH*WIDTH-1:0]     stage_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [CNT_W-1:0]           accept_cnt_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;

  logic [DEPTH-1:0] valid_reg;
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0] moves;
  logic [DEPTH:0]   load_ext;   // bit DEPTH stands for the downstream sink
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [CNT_W-1:0] accept_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_next;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W-1:0] drop_now;
  logic [SUM_W-1:0] drop_sum;

  // Resolve the move/load chain from the output end back to stage 0 in one pass.
  always_comb begin
    moves    = '0;
    load_ext = '0;
    load_ext[DEPTH] = out_ready;
    for (int k = DEPTH-1; k >= 0; k--) begin
      moves[k]    = valid_reg[k] & ~flush_i[k] & ~stall_i[k] & load_ext[k+1];
      load_ext[k] = ~flush_i[k] & ~stall_i[k] & (~valid_reg[k] | moves[k]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        assign src_valid[gi] = in_valid;
        assign src_data[gi]  = in_data;
      end else begin : g_src_prev
        assign src_valid[gi] = moves[gi-1];
        assign src_data[gi]  = data_reg[gi-1];
      end

      // Stage register: flush clears, load takes the source (or empties), else hold.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else if (flush_i[gi]) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else if (load_ext[gi]) begin
          valid_reg[gi] <= src_valid[gi];
          if (src_valid[gi]) begin
            data_reg[gi] <= src_data[gi];
          end
        end
      end

      assign stage_data_o[gi*WIDTH +: WIDTH] = data_reg[gi];
    end
  endgenerate

  // Count valid stages and valid stages being flushed this cycle.
  always_comb begin
    occupancy = '0;
    drop_now  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(valid_reg[k]);
      drop_now  = drop_now + OCC_W'(valid_reg[k] & flush_i[k]);
    end
    drop_sum      = SUM_W'(drop_cnt_reg) + SUM_W'(drop_now);
    drop_cnt_next = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  // Accept counter wraps; drop counter saturates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      accept_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      if (in_valid && load_ext[0]) begin
        accept_cnt_reg <= accept_cnt_reg + 1'b1;
      end
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign in_ready      = load_ext[0];
  assign out_valid     = valid_reg[DEPTH-1] & ~flush_i[DEPTH-1] & ~stall_i[DEPTH-1];
  assign out_data      = data_reg[DEPTH-1];
  assign stage_valid_o = valid_reg;
  assign occupancy_o   = occupancy;
  assign accept_cnt_o  = accept_cnt_reg;
  assign drop_cnt_o    = drop_cnt_reg;
endmodule
